// File: rtl/usb_pkg.sv
// Shared definitions for the USB bit-stream encoder: FSM states, sync pattern,
// bit-stuffing limit, CRC16 constants and the NRZI level helper.
package usb_pkg;

  typedef enum logic [2:0] {IDLE, SYNC, DATA, CRC, EOP} usb_state_e;

  // Raw sync bits, bit i is sent i-th (six zeros then a one).
  localparam logic [6:0]  SYNC_BITS   = 7'b100_0000;
  localparam logic [2:0]  SYNC_LAST   = 3'd6;
  localparam logic [2:0]  STUFF_LIMIT = 3'd6;
  localparam logic [15:0] CRC16_POLY  = 16'h8005;
  localparam logic [15:0] CRC16_INIT  = 16'hFFFF;

  // NRZI: a raw 1 keeps the line level, a raw 0 toggles it.
  function automatic logic nrzi_level(input logic raw, input logic level);
    return raw ? level : ~level;
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// Serial CRC16 (x^16+x^15+x^2+1), one data bit per enabled cycle, data fed
// LSB first. Feeding din_i = crc_o[15] turns the register into a plain left
// shifter, which the encoder uses to stream the result out MSB first.
module usb_crc16 import usb_pkg::*; (
  input  logic        clk,
  input  logic        rst_L,
  input  logic        clear_i,
  input  logic        enable_i,
  input  logic        din_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;
  logic        fb;

  // Next CRC: clear has priority over a data step.
  always_comb begin
    crc_d = crc_q;
    fb    = crc_q[15] ^ din_i;
    if (clear_i) begin
      crc_d = CRC16_INIT;
    end else if (enable_i) begin
      crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
  end

  // CRC register.
  always_ff @(posedge clk) begin
    if (!rst_L) crc_q <= CRC16_INIT;
    else        crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/bit_stream_encoder.sv
// USB bit-stream encoder: sync, NRZI, bit stuffing, EOP timing and underrun
// abort. Optional CRC16 trailer is built when USB_CRC16_EN is defined.
module bit_stream_encoder import usb_pkg::*; (
  input  logic       clk,
  input  logic       rst_L,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       byte_first,
  input  logic       byte_last,
  output logic       byte_ready,
  input  logic       usb_ready,
  output logic       data_start,
  output logic       data_bit,
  output logic       data_end,
  output logic       busy,
  output logic       underrun
);

  usb_state_e  state_q, state_d;
  logic [7:0]  hold_q, hold_d, shift_q, shift_d;
  logic        hold_vld_q, hold_vld_d, hold_first_q, hold_first_d;
  logic        hold_last_q, hold_last_d, cur_last_q, cur_last_d;
  logic [4:0]  cnt_q, cnt_d;    // sync index / bits left / EOP cycle
  logic [2:0]  ones_q, ones_d, ones_n;
  logic        level_q, level_d, urun_q, urun_d;
  logic        emit, raw, stuff, boundary, take, store;
`ifdef USB_CRC16_EN
  logic        pid_q, pid_d, crc_en, crc_din;
  logic [15:0] crc;

  usb_crc16 u_crc (
    .clk      (clk),
    .rst_L    (rst_L),
    .clear_i  (data_start),
    .enable_i (crc_en),
    .din_i    (crc_din),
    .crc_o    (crc)
  );
`endif

  // Bit source, NRZI/stuff tracking, state transitions and holding register.
  always_comb begin
    state_d = state_q;  hold_d = hold_q;  hold_vld_d = hold_vld_q;
    hold_first_d = hold_first_q;  hold_last_d = hold_last_q;
    shift_d = shift_q;  cnt_d = cnt_q;  cur_last_d = cur_last_q;
    ones_d = ones_q;  level_d = level_q;  urun_d = urun_q;
    data_start = 1'b0;  data_end = 1'b0;  underrun = 1'b0;  data_bit = 1'b0;
    emit = 1'b0;  raw = 1'b0;  stuff = 1'b0;  boundary = 1'b0;  take = 1'b0;
`ifdef USB_CRC16_EN
    pid_d = pid_q;  crc_en = 1'b0;  crc_din = 1'b0;
`endif
    // Non-first bytes arriving while idle are accepted and discarded.
    store = byte_valid && !hold_vld_q && !(state_q == IDLE && !byte_first);

    case (state_q)
      SYNC: begin
        emit = 1'b1;
        raw  = SYNC_BITS[cnt_q[2:0]];
      end
      DATA, CRC: begin
        emit  = 1'b1;
        stuff = (ones_q == STUFF_LIMIT);
        if (stuff)                raw = 1'b0;
        else if (state_q == DATA) raw = shift_q[0];
`ifdef USB_CRC16_EN
        else                      raw = ~crc[15];
`else
        else                      raw = 1'b0;
`endif
      end
      default: ;
    endcase

    ones_n = raw ? ones_q + 3'd1 : 3'd0;
    if (emit) begin
      ones_d   = ones_n;
      level_d  = nrzi_level(raw, level_q);
      data_bit = level_d;
    end

    case (state_q)
      IDLE: begin
        if (hold_vld_q) begin
          if (!hold_first_q) begin
            take = 1'b1;
          end else if (usb_ready) begin
            data_start = 1'b1;  take = 1'b1;  state_d = SYNC;
            shift_d = hold_q;  cur_last_d = hold_last_q;
            cnt_d = 5'd0;  ones_d = 3'd0;  level_d = 1'b0;  urun_d = 1'b0;
`ifdef USB_CRC16_EN
            pid_d = 1'b1;
`endif
          end
        end
      end
      SYNC: begin
        if (cnt_q[2:0] == SYNC_LAST) begin
          state_d = DATA;
          cnt_d   = 5'd8;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      DATA, CRC: begin
        if (!stuff) begin
          cnt_d   = cnt_q - 5'd1;
          shift_d = {1'b0, shift_q[7:1]};
`ifdef USB_CRC16_EN
          crc_en  = (state_q == CRC) || !pid_q;
          crc_din = (state_q == DATA) ? shift_q[0] : crc[15];
`endif
        end
        // A stuff bit owed after the final bit postpones the byte boundary.
        boundary = stuff ? (cnt_q == 5'd0)
                         : (cnt_q == 5'd1 && ones_n != STUFF_LIMIT);
        if (boundary) begin
          if (state_q == DATA && !cur_last_q) begin
            if (hold_vld_q) begin
              take = 1'b1;  shift_d = hold_q;  cur_last_d = hold_last_q;
              cnt_d = 5'd8;
`ifdef USB_CRC16_EN
              pid_d = 1'b0;
`endif
            end else begin
              state_d = EOP;  cnt_d = 5'd0;  urun_d = 1'b1;
            end
          end
`ifdef USB_CRC16_EN
          else if (state_q == DATA) begin
            state_d = CRC;  cnt_d = 5'd16;  pid_d = 1'b0;
          end
`endif
          else begin
            state_d = EOP;  cnt_d = 5'd0;
          end
        end
      end
      EOP: begin
        if (cnt_q == 5'd0) begin
          data_end = 1'b1;
          underrun = urun_q;
        end
        if (cnt_q == 5'd2) begin
          state_d = IDLE;  cnt_d = 5'd0;  urun_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) hold_vld_d = 1'b0;
    if (store) begin
      hold_d = byte_in;  hold_vld_d = 1'b1;
      hold_first_d = byte_first;  hold_last_d = byte_last;
    end
  end

  // State and datapath registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_L) begin
      state_q <= IDLE;  hold_q <= '0;  hold_vld_q <= 1'b0;
      hold_first_q <= 1'b0;  hold_last_q <= 1'b0;  shift_q <= '0;
      cnt_q <= '0;  cur_last_q <= 1'b0;  ones_q <= '0;
      level_q <= 1'b0;  urun_q <= 1'b0;
`ifdef USB_CRC16_EN
      pid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;  hold_q <= hold_d;  hold_vld_q <= hold_vld_d;
      hold_first_q <= hold_first_d;  hold_last_q <= hold_last_d;
      shift_q <= shift_d;  cnt_q <= cnt_d;  cur_last_q <= cur_last_d;
      ones_q <= ones_d;  level_q <= level_d;  urun_q <= urun_d;
`ifdef USB_CRC16_EN
      pid_q <= pid_d;
`endif
    end
  end

  assign byte_ready = ~hold_vld_q;
  assign busy       = (state_q != IDLE);

endmodule
